uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit buffer placed directly upstream of the UART transceiver. It accepts bytes from the CSR/DMA side at up to one per cycle and stores them in a circular FIFO. Bytes are handed to the transceiver one at a time using its tx_data/tx_wr/tx_done handshake. It also reports fill level, overflow and a "drained" interrupt, so software no longer polls per byte.

Parameters:
depth_log2, 4, FIFO holds 2**depth_log2 bytes (legal range 1..8)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  synchronous reset, active-low
wr_data  in  8  byte to enqueue
wr_en  in  1  enqueue strobe, one byte per cycle
flush  in  1  discard all queued bytes
clr_overflow  in  1  clear sticky overflow flag
full  out  1  FIFO holds 2**depth_log2 bytes
empty  out  1  FIFO holds 0 bytes
level  out  depth_log2+1  current byte count
overflow  out  1  sticky: a write was dropped
busy  out  1  FSM not in IDLE (byte in flight)
tx_data  out  8  byte presented to transceiver
tx_wr  out  1  one-cycle start strobe to transceiver
tx_done  in  1  one-cycle pulse from transceiver, byte sent
drained_irq  out  1  one-cycle pulse: last byte finished and FIFO empty

Behaviour:
- Reset (sys_rst_n=0 at an edge): pointers=0, level=0, empty=1, full=0, overflow=0, busy=0, tx_wr=0, tx_data=0, drained_irq=0, FSM=IDLE.
- Storage: 2**depth_log2 x 8 array. Read and write pointers are depth_log2 bits wide and wrap modulo depth. level is kept as a separate counter; full=(level==depth), empty=(level==0). All outputs are registered or derived from registers.
- Write acceptance: the write is accepted iff wr_en & !flush & (!full | pop), where pop is this cycle's dequeue. A simultaneous write and pop leaves level unchanged.
- Dropped write: wr_en & full & !pop & !flush sets overflow. overflow clears only on clr_overflow; if set and clear occur in the same cycle, set wins.
- flush: at the next edge, read pointer := write pointer and level := 0. A write in the same cycle is dropped silently (no overflow). A pop in the same cycle still completes. flush does not abort a byte already handed to the transceiver.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: if !empty, pop at this edge, latch the head byte into tx_data, go to SEND. Otherwise stay.
  - SEND: tx_wr=1 for exactly this one cycle, then go to WAIT. tx_data stays stable from SEND until the next pop.
  - WAIT: on tx_done, if !empty (after any same-cycle flush), pop and go to SEND. If empty, go to IDLE and pulse drained_irq for one cycle. Without tx_done, stay.
- Latency: a byte written into an empty FIFO with the FSM in IDLE at edge N gives tx_wr=1 during the cycle following edge N+1. Back-to-back bytes: tx_wr falls 2 cycles after the tx_done of the previous byte.
- tx_done received in IDLE or SEND is ignored. This covers a transceiver still finishing a byte after reset.
- busy=1 in SEND and WAIT. Software pending status = busy | !empty.
- level never exceeds depth and never underflows. A pop is only issued when !empty.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, SEND=2'd1, WAIT=2'd2) and the default depth_log2.
- One sub-module, uart_fifo_ram: a 2**depth_log2 x 8 dual-port RAM with synchronous write and asynchronous read, so it can map to distributed RAM.
- Pointers, level, flags and FSM live in uart_tx_fifo.

Test Plan:
- Single byte: write 0x55 into empty FIFO at edge N -> tx_wr=1 with tx_data=0x55 in cycle after N+1. Then pulse tx_done -> drained_irq pulse 1 cycle later, busy=0, empty=1.
- Fill with depth_log2=4: write 17 bytes 0x00..0x10 while tx_done is withheld -> first byte popped, level reaches 16, full=1 after byte 0x10 accepted. Then write 0x11 -> dropped, overflow=1.
- Drain order: pulse tx_done repeatedly -> tx_data sequence 0x00..0x10 in order, pointer wrap correct. drained_irq fires exactly once, after the last tx_done.
- Simultaneous: with full=1 and FSM in WAIT, assert tx_done and wr_en(0xAA) in the same cycle -> 0xAA accepted, level stays 16, overflow unchanged.
- Flush: queue 5 bytes with one in flight, then flush plus wr_en same cycle -> level=0, write dropped, overflow=0, busy stays 1. On tx_done -> IDLE plus drained_irq.
- Reset mid-transfer: sys_rst_n=0 while in WAIT with level=3 -> all outputs at reset values. A stray tx_done after reset -> no tx_wr, no drained_irq.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: sequencer state encodings
// and the default FIFO depth.
package uart_tx_fifo_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte-wide dual-port storage: synchronous write, asynchronous read, so it
// maps onto distributed RAM.
module uart_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned depth_log2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [depth_log2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [depth_log2-1:0] raddr,
  output logic [7:0]            rdata
);

  localparam int unsigned DEPTH = 1 << depth_log2;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO feeding the UART transceiver one byte at a time over
// the tx_data/tx_wr/tx_done handshake, with level, overflow and drained status.
//
// Handshake: a byte is presented on tx_data when tx_wr pulses for one cycle;
// tx_data then holds until the transceiver answers with a one-cycle tx_done,
// which is only honoured while waiting on a byte (WAIT state).
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned depth_log2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [7:0]          wr_data,
  input  logic                wr_en,
  input  logic                flush,
  input  logic                clr_overflow,
  output logic                full,
  output logic                empty,
  output logic [depth_log2:0] level,
  output logic                overflow,
  output logic                busy,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  input  logic                tx_done,
  output logic                drained_irq
);

  localparam int unsigned LW    = depth_log2 + 1;
  localparam int unsigned DEPTH = 1 << depth_log2;

  tx_state_e             state_q, state_d;
  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_wr_q, tx_wr_d;
  logic                  drained_q, drained_d;

  logic                  pop;
  logic                  wr_accept;
  logic [7:0]            head_byte;

  assign full        = (level_q == LW'(DEPTH));
  assign empty       = (level_q == '0);
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;
  assign tx_data     = tx_data_q;
  assign tx_wr       = tx_wr_q;
  assign drained_irq = drained_q;

  uart_fifo_ram #(
    .depth_log2 (depth_log2)
  ) u_ram (
    .clk   (sys_clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (head_byte)
  );

  // Sequencer: decides when the head byte is dequeued toward the transceiver.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    drained_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          // A same-cycle flush empties the queue before this decision.
          if (!empty && !flush) begin
            pop     = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d   = ST_IDLE;
            drained_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_data_d = pop ? head_byte : tx_data_q;
    tx_wr_d   = (state_d == ST_SEND);
    busy_d    = (state_d != ST_IDLE);
  end

  // Queue bookkeeping: pointers, level and sticky overflow.
  always_comb begin
    wr_accept  = wr_en && !flush && (!full || pop);
    wr_ptr_d   = wr_ptr_q + depth_log2'(wr_accept);
    rd_ptr_d   = flush ? wr_ptr_q : rd_ptr_q + depth_log2'(pop);
    level_d    = flush ? '0 : level_q + LW'(wr_accept) - LW'(pop);
    overflow_d = (overflow_q && !clr_overflow) ||
                 (wr_en && full && !pop && !flush);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      drained_q  <= drained_d;
    end
  end

endmodule
